// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants and helpers for the io_port_bank slice.
//   REG_DATA/REG_DIR/REG_FLAG/REG_MASK : register offsets carried in addr[1:0]
//   addr_width()                       : bus address width for a given port count
package io_port_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DIR  = 2'd1;
    localparam logic [1:0] REG_FLAG = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    // Two register-select bits plus enough bits to index every port.
    function automatic int addr_width(input int nports);
        return $clog2(nports) + 2;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: CPU bus strobes and address for the port bank.
//   read, write : bus strobes
//   addr        : [1:0] register select, upper bits port index
// The tri-state data bus is a plain inout on the bank so that it resolves
// directly against the other bus drivers.
interface io_port_bank_if
    import io_port_pkg::*;
#(
    parameter int NPORTS = 4
);
    localparam int AW = addr_width(NPORTS);

    logic          read;
    logic          write;
    logic [AW-1:0] addr;

    modport master (output read, output write, output addr);
    modport slave  (input  read, input  write, input  addr);

endinterface

// File: rtl/io_port_channel.sv
// io_port_channel: one bidirectional I/O port.
//   clk, reset   : clock, synchronous active-high reset
//   i_armed      : change detection enabled (shared arm counter)
//   i_wr_en      : bus write aimed at this port
//   i_reg        : register select
//   i_wr_data    : bus write data
//   i_pins       : raw asynchronous pin levels
//   o_latch      : output latch (drives pins_out)
//   o_dir        : direction, 1 = output (drives pins_oe)
//   o_rd_data    : value of the selected register for a bus read
//   o_irq        : OR of FLAG & MASK
module io_port_channel
    import io_port_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_armed,
    input  logic             i_wr_en,
    input  logic [1:0]       i_reg,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_latch,
    output logic [WIDTH-1:0] o_dir,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_irq
);

    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_flag;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;

    // Output bits never flag; r_dir is the pre-edge value, so a bit turning
    // input only joins detection one edge after its DIR write.
    assign w_set = (r_s2 ^ r_prev) & ~r_dir & {WIDTH{i_armed}};
    assign w_clr = (i_wr_en && (i_reg == REG_FLAG)) ? i_wr_data : {WIDTH{1'b0}};

    // Synchroniser, change history, flags and CPU-writable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch <= {WIDTH{1'b0}};
            r_dir   <= {WIDTH{1'b0}};
            r_flag  <= {WIDTH{1'b0}};
            r_mask  <= {WIDTH{1'b0}};
            r_s1    <= {WIDTH{1'b0}};
            r_s2    <= {WIDTH{1'b0}};
            r_prev  <= {WIDTH{1'b0}};
        end else begin
            r_s1   <= i_pins;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // Set is ORed after the clear so a same-edge set survives W1C.
            r_flag <= (r_flag & ~w_clr) | w_set;
            if (i_wr_en) begin
                case (i_reg)
                    REG_DATA: r_latch <= i_wr_data;
                    REG_DIR:  r_dir   <= i_wr_data;
                    REG_MASK: r_mask  <= i_wr_data;
                    default:  ;  // REG_FLAG handled through w_clr
                endcase
            end
        end
    end

    // Register read-back; DATA mixes latch (outputs) and synchronised pins (inputs).
    always_comb begin
        o_rd_data = {WIDTH{1'b0}};
        case (i_reg)
            REG_DATA: o_rd_data = (r_latch & r_dir) | (r_s2 & ~r_dir);
            REG_DIR:  o_rd_data = r_dir;
            REG_FLAG: o_rd_data = r_flag;
            REG_MASK: o_rd_data = r_mask;
            default:  o_rd_data = {WIDTH{1'b0}};
        endcase
    end

    assign o_latch = r_latch;
    assign o_dir   = r_dir;
    assign o_irq   = |(r_flag & r_mask);

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: NPORTS bidirectional ports behind one CPU bus slave.
//   clk, reset : clock, synchronous active-high reset
//   bus        : read/write strobes and address (slave modport)
//   data_bus   : shared tri-state data bus, driven only for a pure read
//   pins_in    : raw pin levels, port p at [p*WIDTH +: WIDTH]
//   pins_out   : output latches
//   pins_oe    : per-bit output enables (DIR)
//   irq        : OR over all ports of FLAG & MASK
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NPORTS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    io_port_bank_if.slave           bus,
    inout  wire  [WIDTH-1:0]        data_bus,
    input  logic [NPORTS*WIDTH-1:0] pins_in,
    output logic [NPORTS*WIDTH-1:0] pins_out,
    output logic [NPORTS*WIDTH-1:0] pins_oe,
    output logic                    irq
);

    localparam int AW = addr_width(NPORTS);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [1:0]       r_arm_cnt;
    logic             w_armed;
    logic [PW-1:0]    w_port;
    logic [1:0]       w_reg;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_drive;
    logic [WIDTH-1:0] w_ch_rd [NPORTS];
    logic [NPORTS-1:0] w_irq_vec;

    generate
        if (NPORTS > 1) begin : g_port_idx
            assign w_port = bus.addr[AW-1:2];
        end else begin : g_single_port
            assign w_port = 1'b0;
        end
    endgenerate
    assign w_reg = bus.addr[1:0];

    // Arm counter: holds off flags until s1/s2/prev hold real pin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm_cnt <= 2'd0;
        end else if (r_arm_cnt != 2'd3) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
        end else begin
            r_arm_cnt <= r_arm_cnt;
        end
    end
    assign w_armed = (r_arm_cnt == 2'd3);

    // Port indices without a channel match no iteration: writes vanish, reads return zero.
    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_ch
            io_port_channel #(.WIDTH(WIDTH)) u_ch (
                .clk       (clk),
                .reset     (reset),
                .i_armed   (w_armed),
                .i_wr_en   (bus.write && (w_port == PW'(p))),
                .i_reg     (w_reg),
                .i_wr_data (data_bus),
                .i_pins    (pins_in[p*WIDTH +: WIDTH]),
                .o_latch   (pins_out[p*WIDTH +: WIDTH]),
                .o_dir     (pins_oe[p*WIDTH +: WIDTH]),
                .o_rd_data (w_ch_rd[p]),
                .o_irq     (w_irq_vec[p])
            );
        end
    endgenerate

    // Read mux over the addressed port.
    always_comb begin
        w_rd_data = {WIDTH{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            if (w_port == PW'(i)) begin
                w_rd_data = w_ch_rd[i];
            end else begin
                w_rd_data = w_rd_data;
            end
        end
    end

    // A write wins over a simultaneous read; reset releases the bus at once.
    assign w_drive  = bus.read && !bus.write && !reset;
    assign data_bus = w_drive ? w_rd_data : {WIDTH{1'bz}};
    assign irq      = |w_irq_vec;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed self-checking bench for io_port_bank.
// Five ports are instantiated: with a 5-bit address the port field reaches
// indices 5..7, which have no channel behind them.
module tb_io_port_bank;
    import io_port_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NPORTS = 5;
    localparam int PINW   = NPORTS * WIDTH;

    logic            clk;
    logic            reset;
    logic [PINW-1:0] pins_in;
    logic [PINW-1:0] pins_out;
    logic [PINW-1:0] pins_oe;
    logic            irq;
    wire  [WIDTH-1:0] data_bus;
    logic            tb_drv_en;
    logic [WIDTH-1:0] tb_drv;
    int              n_tests;
    int              n_fail;

    io_port_bank_if #(.NPORTS(NPORTS)) u_bus ();

    assign data_bus = tb_drv_en ? tb_drv : {WIDTH{1'bz}};

    io_port_bank #(.WIDTH(WIDTH), .NPORTS(NPORTS)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (u_bus),
        .data_bus (data_bus),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .pins_oe  (pins_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int port, input logic [1:0] rsel, input logic [15:0] d);
        u_bus.addr  = {3'(port), rsel};
        u_bus.write = 1'b1;
        tb_drv      = d;
        tb_drv_en   = 1'b1;
        step(1);
        u_bus.write = 1'b0;
        tb_drv_en   = 1'b0;
    endtask

    task automatic bus_read(input int port, input logic [1:0] rsel, output logic [15:0] d);
        u_bus.addr = {3'(port), rsel};
        u_bus.read = 1'b1;
        #1;
        d = data_bus;
        u_bus.read = 1'b0;
        #1;
    endtask

    task automatic apply_reset(input logic [PINW-1:0] p);
        pins_in     = p;
        reset       = 1'b1;
        u_bus.read  = 1'b0;
        u_bus.write = 1'b0;
        tb_drv_en   = 1'b0;
        step(2);
        reset = 1'b0;
        step(5);
    endtask

    task automatic test_reset;
        logic [15:0] d;
        pins_in     = {PINW{1'b1}};
        reset       = 1'b1;
        u_bus.read  = 1'b0;
        u_bus.write = 1'b0;
        u_bus.addr  = 5'd0;
        tb_drv_en   = 1'b0;
        tb_drv      = 16'h0000;
        step(2);
        n_tests++; if (pins_out !== {PINW{1'b0}}) begin n_fail++; $display("FAIL reset_pins_out: got %h expected 0", pins_out); end
        n_tests++; if (pins_oe !== {PINW{1'b0}}) begin n_fail++; $display("FAIL reset_pins_oe: got %h expected 0", pins_oe); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        step(5);
        for (int p = 0; p < NPORTS; p++) begin
            bus_read(p, REG_FLAG, d);
            n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL arm_suppress_flag port %0d: got %h expected 0000", p, d); end
        end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arm_suppress_irq: got %b expected 0", irq); end
    endtask

    task automatic test_port1_io;
        logic [15:0] d;
        apply_reset({PINW{1'b0}});
        bus_write(1, REG_DIR, 16'h00FF);
        bus_write(1, REG_DATA, 16'hA5C3);
        pins_in[16 +: 16] = 16'h1200;
        n_tests++; if (pins_out[16 +: 16] !== 16'hA5C3) begin n_fail++; $display("FAIL p1_pins_out: got %h expected A5C3", pins_out[16 +: 16]); end
        n_tests++; if (pins_oe[16 +: 16] !== 16'h00FF) begin n_fail++; $display("FAIL p1_pins_oe: got %h expected 00FF", pins_oe[16 +: 16]); end
        step(2);
        bus_read(1, REG_DATA, d);
        n_tests++; if (d !== 16'h12C3) begin n_fail++; $display("FAIL p1_data_read: got %h expected 12C3", d); end
        bus_read(1, REG_DIR, d);
        n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL p1_dir_read: got %h expected 00FF", d); end
        step(1);
        bus_read(1, REG_FLAG, d);
        n_tests++; if (d !== 16'h1200) begin n_fail++; $display("FAIL p1_flag_read: got %h expected 1200", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL p1_irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_port2_irq;
        logic [15:0] d;
        apply_reset({PINW{1'b0}});
        bus_write(2, REG_MASK, 16'h0001);
        pins_in[32] = 1'b1;
        step(1);
        bus_read(2, REG_DATA, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL p2_data_edge1: got %h expected 0000", d); end
        step(1);
        bus_read(2, REG_DATA, d);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL p2_data_edge2: got %h expected 0001", d); end
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL p2_flag_edge2: got %h expected 0000", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL p2_irq_edge2: got %b expected 0", irq); end
        step(1);
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL p2_flag_edge3: got %h expected 0001", d); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL p2_irq_edge3: got %b expected 1", irq); end
        bus_write(2, REG_FLAG, 16'h0001);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL p2_irq_w1c: got %b expected 0", irq); end
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL p2_flag_w1c: got %h expected 0000", d); end
    endtask

    task automatic test_set_wins;
        logic [15:0] d;
        apply_reset({PINW{1'b0}});
        bus_write(2, REG_MASK, 16'h0001);
        pins_in[32] = 1'b1;
        step(3);
        pins_in[32] = 1'b0;
        step(2);
        // s2 and prev now differ on bit0: this W1C edge also sets the flag.
        bus_write(2, REG_FLAG, 16'h0001);
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL set_wins_flag: got %h expected 0001", d); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b expected 1", irq); end
        bus_write(2, REG_FLAG, 16'h0001);
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL set_wins_clear_after: got %h expected 0000", d); end
    endtask

    task automatic test_rw_collision;
        logic [15:0] d;
        apply_reset({16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h0000});
        u_bus.addr  = {3'd0, REG_DIR};
        u_bus.read  = 1'b1;
        u_bus.write = 1'b1;
        tb_drv      = 16'hFFFF;
        tb_drv_en   = 1'b1;
        #1;
        n_tests++; if (data_bus !== 16'hFFFF) begin n_fail++; $display("FAIL rw_bus_ffff: got %h expected FFFF", data_bus); end
        step(1);
        n_tests++; if (pins_oe[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL rw_dir_ffff: got %h expected FFFF", pins_oe[15:0]); end
        // DIR now holds FFFF, so any DUT drive would show against the bench's zero.
        tb_drv = 16'h0000;
        #1;
        n_tests++; if (data_bus !== 16'h0000) begin n_fail++; $display("FAIL rw_bus_released: got %h expected 0000", data_bus); end
        step(1);
        u_bus.read  = 1'b0;
        u_bus.write = 1'b0;
        tb_drv_en   = 1'b0;
        n_tests++; if (pins_oe[15:0] !== 16'h0000) begin n_fail++; $display("FAIL rw_dir_0000: got %h expected 0000", pins_oe[15:0]); end
        bus_write(5, REG_DATA, 16'hBEEF);
        bus_write(5, REG_DIR, 16'hFFFF);
        bus_write(7, REG_DATA, 16'h1234);
        n_tests++; if (pins_out !== {PINW{1'b0}}) begin n_fail++; $display("FAIL bad_port_pins_out: got %h expected 0", pins_out); end
        n_tests++; if (pins_oe !== {PINW{1'b0}}) begin n_fail++; $display("FAIL bad_port_pins_oe: got %h expected 0", pins_oe); end
        bus_read(5, REG_DATA, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL bad_port_read5: got %h expected 0000", d); end
        bus_read(1, REG_DATA, d);
        n_tests++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL port1_pin_read: got %h expected 00FF", d); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        apply_reset({PINW{1'b0}});
        bus_write(0, REG_DIR, 16'hFFFF);
        bus_write(0, REG_DATA, 16'h1234);
        bus_write(2, REG_MASK, 16'h0001);
        pins_in[32] = 1'b1;
        step(3);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_setup_irq: got %b expected 1", irq); end
        u_bus.addr = {3'd0, REG_DIR};
        u_bus.read = 1'b1;
        tb_drv     = 16'h0000;
        tb_drv_en  = 1'b1;
        reset      = 1'b1;
        #1;
        n_tests++; if (data_bus !== 16'h0000) begin n_fail++; $display("FAIL mid_bus_release: got %h expected 0000", data_bus); end
        step(1);
        u_bus.read = 1'b0;
        tb_drv_en  = 1'b0;
        n_tests++; if (pins_out !== {PINW{1'b0}}) begin n_fail++; $display("FAIL mid_pins_out: got %h expected 0", pins_out); end
        n_tests++; if (pins_oe !== {PINW{1'b0}}) begin n_fail++; $display("FAIL mid_pins_oe: got %h expected 0", pins_oe); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b expected 0", irq); end
        reset = 1'b0;
        step(5);
        bus_read(2, REG_FLAG, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_flag_rearm: got %h expected 0000", d); end
        bus_read(2, REG_MASK, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_mask: got %h expected 0000", d); end
        bus_read(2, REG_DATA, d);
        n_tests++; if (d !== 16'h0001) begin n_fail++; $display("FAIL mid_pin_resync: got %h expected 0001", d); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_port1_io();
        test_port2_irq();
        test_set_wins();
        test_rw_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
